// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch/branch unit.
//   fetch_state_t : sequencer states, exported on dbg_state for checkers
//   OP_BR / OP_JMP: 3-bit opcode field values (instr[8:6])
//   HALT_WORD     : instruction word that stops the sequencer until reset
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    DECODE = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

  localparam logic [2:0] OP_BR     = 3'b110;
  localparam logic [2:0] OP_JMP    = 3'b111;
  localparam logic [8:0] HALT_WORD = 9'h1FF;

endpackage

// File: rtl/branch_lut.sv
// branch_lut: 2^L x D branch-target register file.
//   clk, reset      : clock, asynchronous active-high reset (clears all entries)
//   we/waddr/wdata  : synchronous write port
//   raddr/rdata     : combinational read port
// A write and a read of the same entry in one cycle returns the old value,
// because the write only lands at the clock edge.
module branch_lut #(
  parameter int L = 5,
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [L-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [L-1:0] raddr,
  output logic [D-1:0] rdata
);

  logic [D-1:0] mem [2**L];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**L; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: consumer side of the program counter.
// Once per instruction period (CYCLES clocks) it fetches the word at prog_ctr,
// publishes it on instr/instr_valid, and raises branchFlag/target for the PC
// when the word is a JMP, or a BR with cond_flag set.
//   clk, reset            : clock, asynchronous active-high reset
//   prog_ctr              : current PC, sampled when the read is launched
//   cond_flag             : branch condition, sampled in the DECODE cycle
//   imem_rd/imem_addr     : read request, a one-cycle strobe with its address
//   imem_data             : read data, sampled ROM_LAT clock edges after the
//                           edge that raised imem_rd, ignored otherwise
//   lut_we/waddr/wdata    : branch-target LUT write port (any state)
//   instr/instr_valid     : latched instruction and its one-cycle pulse
//   branchFlag/target     : branch request held through the period's last phase
//   halt                  : sticky, set by HALT_WORD, cleared only by reset
//   dbg_state             : current sequencer state
// Read protocol: imem_rd is a request strobe with no back-pressure; the memory
// must answer with fixed latency, so there is no ready signal.
module fetch_branch_unit
  import fetch_pkg::*;
#(
  parameter int D        = 12,
  parameter int W        = 9,
  parameter int CYCLES   = 10,
  parameter int FETCH_PH = 1,
  parameter int ROM_LAT  = 1,
  parameter int L        = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  input  logic         cond_flag,
  output logic         imem_rd,
  output logic [D-1:0] imem_addr,
  input  logic [W-1:0] imem_data,
  input  logic         lut_we,
  input  logic [L-1:0] lut_waddr,
  input  logic [D-1:0] lut_wdata,
  output logic [W-1:0] instr,
  output logic         instr_valid,
  output logic         branchFlag,
  output logic [D-1:0] target,
  output logic         halt,
  output fetch_state_t dbg_state
);

  if (FETCH_PH + ROM_LAT + 2 > CYCLES - 1) begin : g_bad_phase
    $fatal(1, "fetch_branch_unit: FETCH_PH+ROM_LAT+2 must not exceed CYCLES-1");
  end
  if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_lat
    $fatal(1, "fetch_branch_unit: ROM_LAT must be 1..3");
  end

  localparam int              PH_W     = $clog2(CYCLES);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CYCLES - 1);
  localparam logic [PH_W-1:0] PH_FETCH = PH_W'(FETCH_PH);
  localparam logic [1:0]      LAT_INIT = 2'(ROM_LAT);

  fetch_state_t    state;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;
  logic [1:0]      lat_cnt;
  logic [D-1:0]    lut_rdata;
  logic [2:0]      opcode;
  logic            take_branch;

  assign ph_nxt      = (ph == PH_LAST) ? '0 : ph + PH_W'(1);
  assign opcode      = instr[W-1 -: 3];
  assign take_branch = (opcode == OP_JMP) || ((opcode == OP_BR) && cond_flag);
  assign dbg_state   = state;

  branch_lut #(.L(L), .D(D)) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (instr[L-1:0]),
    .rdata (lut_rdata)
  );

  // Outputs are registered, so actions are keyed on ph_nxt: the read strobe
  // is high during the cycle in which ph==FETCH_PH, and branchFlag drops in
  // the cycle in which ph==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ph          <= '0;
      lat_cnt     <= '0;
      imem_rd     <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      branchFlag  <= 1'b0;
      target      <= '0;
      halt        <= 1'b0;
    end else begin
      imem_rd     <= 1'b0;
      instr_valid <= 1'b0;
      if (state != HALTED) begin
        ph <= ph_nxt;
      end
      case (state)
        IDLE: begin
          if (ph_nxt == PH_FETCH) begin
            imem_rd   <= 1'b1;
            imem_addr <= prog_ctr;
            lat_cnt   <= LAT_INIT;
            state     <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          // Counter reaches zero on this edge: the data is valid now.
          if (lat_cnt == 2'd1) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (instr == HALT_WORD) begin
            halt  <= 1'b1;
            state <= HALTED;
          end else begin
            if (take_branch) begin
              branchFlag <= 1'b1;
              target     <= lut_rdata;
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          // Held through the last phase, where the PC samples it.
          if (ph_nxt == '0) begin
            branchFlag <= 1'b0;
            state      <= IDLE;
          end
        end
        HALTED: begin
          branchFlag <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// tb_fetch_branch_unit: two instances (ROM latency 1 and 3) driven in lockstep
// by the same stimulus; each answered by its own fixed-latency ROM responder.
// Expected behaviour is derived per instruction period from phase arithmetic:
// fetch at FETCH_PH, valid at FETCH_PH+LAT, branch from the next phase up to
// the last one, halt sticky until reset.
module tb_fetch_branch_unit;
  import fetch_pkg::*;

  localparam int D        = 12;
  localparam int W        = 9;
  localparam int CYCLES   = 10;
  localparam int FETCH_PH = 1;
  localparam int L        = 5;
  localparam int LAT0     = 1;
  localparam int LAT1     = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [D-1:0] prog_ctr;
  logic         cond_flag;
  logic         lut_we;
  logic [L-1:0] lut_waddr;
  logic [D-1:0] lut_wdata;

  logic         rd   [2];
  logic [D-1:0] addr [2];
  logic [W-1:0] dat  [2];
  logic [W-1:0] ins  [2];
  logic         vld  [2];
  logic         br   [2];
  logic [D-1:0] tgt  [2];
  logic         hlt  [2];
  fetch_state_t st   [2];

  fetch_branch_unit #(.D(D), .W(W), .CYCLES(CYCLES), .FETCH_PH(FETCH_PH),
                      .ROM_LAT(LAT0), .L(L)) u_dut0 (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .cond_flag(cond_flag),
    .imem_rd(rd[0]), .imem_addr(addr[0]), .imem_data(dat[0]),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .instr(ins[0]), .instr_valid(vld[0]), .branchFlag(br[0]),
    .target(tgt[0]), .halt(hlt[0]), .dbg_state(st[0])
  );

  fetch_branch_unit #(.D(D), .W(W), .CYCLES(CYCLES), .FETCH_PH(FETCH_PH),
                      .ROM_LAT(LAT1), .L(L)) u_dut1 (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .cond_flag(cond_flag),
    .imem_rd(rd[1]), .imem_addr(addr[1]), .imem_data(dat[1]),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .instr(ins[1]), .instr_valid(vld[1]), .branchFlag(br[1]),
    .target(tgt[1]), .halt(hlt[1]), .dbg_state(st[1])
  );

  // ---------------- ROM responders ----------------
  // Data is sampled LAT edges after the edge that raised imem_rd, so it must
  // be present during cycle (rd cycle + LAT - 1); random noise elsewhere.
  logic [W-1:0] rom [0:(1<<D)-1];
  logic [W-1:0] noise;
  logic [1:0]   rd_hist1 = '0;
  logic [D-1:0] ad_hist1 [2];

  always @(posedge clk) begin
    noise       <= W'($urandom);
    rd_hist1    <= {rd_hist1[0], rd[1]};
    ad_hist1[0] <= addr[1];
    ad_hist1[1] <= ad_hist1[0];
  end

  assign dat[0] = rd[0]       ? rom[addr[0]]      : noise;
  assign dat[1] = rd_hist1[1] ? rom[ad_hist1[1]]  : noise;

  // ---------------- reference model state ----------------
  int           ph_m;
  bit           halted_m [2];
  bit           taken_m  [2];
  logic [D-1:0] tgt_m    [2];
  logic [W-1:0] cur_word [2];
  logic [D-1:0] addr_m;
  logic [D-1:0] lut_m [1<<L];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int dec_ph(input int k);
    return FETCH_PH + ((k == 0) ? LAT0 : LAT1);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      bit live;
      int dec;
      live = !halted_m[k];
      dec  = dec_ph(k);
      check_eq($sformatf("u%0d.imem_rd ph%0d", k, ph_m), 32'(rd[k]), 32'(live && ph_m == FETCH_PH));
      check_eq($sformatf("u%0d.instr_valid ph%0d", k, ph_m), 32'(vld[k]), 32'(live && ph_m == dec));
      check_eq($sformatf("u%0d.branchFlag ph%0d", k, ph_m), 32'(br[k]),
               32'(live && taken_m[k] && ph_m > dec));
      check_eq($sformatf("u%0d.halt", k), 32'(hlt[k]), 32'(halted_m[k]));
      check_eq($sformatf("u%0d.target", k), 32'(tgt[k]), 32'(tgt_m[k]));
      if (live && ph_m == FETCH_PH)
        check_eq($sformatf("u%0d.imem_addr", k), 32'(addr[k]), 32'(addr_m));
      if (live && ph_m == dec) begin
        if (k == 0 && exp_q0.size() > 0) cur_word[k] = exp_q0.pop_front();
        if (k == 1 && exp_q1.size() > 0) cur_word[k] = exp_q1.pop_front();
        check_eq($sformatf("u%0d.instr", k), 32'(ins[k]), 32'(cur_word[k]));
      end
      if (halted_m[k])
        check_eq($sformatf("u%0d.state_halted", k), 32'(st[k]), 32'(HALTED));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic model_reset();
    ph_m   = 0;
    addr_m = '0;
    for (int k = 0; k < 2; k++) begin
      halted_m[k] = 1'b0;
      taken_m[k]  = 1'b0;
      tgt_m[k]    = '0;
      cur_word[k] = '0;
    end
    for (int i = 0; i < (1<<L); i++) lut_m[i] = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Called at a negedge: asserts reset mid-cycle, checks the asynchronous
  // clear before the next rising edge, then releases on a later negedge.
  task automatic apply_reset();
    lut_we = 1'b0;
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("u%0d.rst_imem_rd", k), 32'(rd[k]), 32'd0);
      check_eq($sformatf("u%0d.rst_imem_addr", k), 32'(addr[k]), 32'd0);
      check_eq($sformatf("u%0d.rst_instr", k), 32'(ins[k]), 32'd0);
      check_eq($sformatf("u%0d.rst_instr_valid", k), 32'(vld[k]), 32'd0);
      check_eq($sformatf("u%0d.rst_branchFlag", k), 32'(br[k]), 32'd0);
      check_eq($sformatf("u%0d.rst_target", k), 32'(tgt[k]), 32'd0);
      check_eq($sformatf("u%0d.rst_halt", k), 32'(hlt[k]), 32'd0);
      check_eq($sformatf("u%0d.rst_state", k), 32'(st[k]), 32'(IDLE));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drives inputs for the coming edge, advances the model across that edge,
  // then checks the outputs half a cycle later.
  task automatic do_cycle(input logic [D-1:0] pc, input bit cond, input int wr_ph,
                          input logic [L-1:0] wr_idx, input logic [D-1:0] wr_data,
                          input bit rand_wr);
    int fetch_prev;
    fetch_prev = (FETCH_PH + CYCLES - 1) % CYCLES;
    prog_ctr  = (ph_m == fetch_prev || ph_m == FETCH_PH) ? pc : D'($urandom);
    cond_flag = (ph_m == dec_ph(0) || ph_m == dec_ph(1)) ? cond : 1'($urandom);
    if (ph_m == wr_ph) begin
      lut_we = 1'b1; lut_waddr = wr_idx; lut_wdata = wr_data;
    end else if (rand_wr && $urandom_range(0, 3) == 0) begin
      lut_we = 1'b1; lut_waddr = L'($urandom_range(4, (1<<L)-1)); lut_wdata = D'($urandom);
    end else begin
      lut_we = 1'b0; lut_waddr = L'($urandom); lut_wdata = D'($urandom);
    end

    for (int k = 0; k < 2; k++) begin
      if (!halted_m[k] && ph_m == dec_ph(k)) begin
        if (cur_word[k] == HALT_WORD) begin
          halted_m[k] = 1'b1;
        end else if (cur_word[k][8:6] == OP_JMP || (cur_word[k][8:6] == OP_BR && cond_flag)) begin
          taken_m[k] = 1'b1;
          tgt_m[k]   = lut_m[cur_word[k][L-1:0]];
        end
      end
    end
    if (lut_we) lut_m[lut_waddr] = lut_wdata;
    ph_m = (ph_m + 1) % CYCLES;
    if (ph_m == 0) begin
      taken_m[0] = 1'b0;
      taken_m[1] = 1'b0;
    end
    if (ph_m == FETCH_PH) begin
      addr_m = prog_ctr;
      if (!halted_m[0]) exp_q0.push_back(rom[prog_ctr]);
      if (!halted_m[1]) exp_q1.push_back(rom[prog_ctr]);
    end

    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_period(input logic [D-1:0] pc, input bit cond, input int ncyc,
                            input int wr_ph, input logic [L-1:0] wr_idx,
                            input logic [D-1:0] wr_data, input bit rand_wr);
    repeat (ncyc) do_cycle(pc, cond, wr_ph, wr_idx, wr_data, rand_wr);
  endtask

  task automatic random_periods(input int n);
    logic [D-1:0] pc;
    for (int i = 0; i < n; i++) begin
      do pc = D'($urandom_range(0, 63)); while (pc == 9);
      run_period(pc, 1'($urandom), CYCLES, -1, '0, '0, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < (1<<D); i++) begin
      rom[i] = W'($urandom);
      if (rom[i] == HALT_WORD) rom[i] = '0;
    end
    rom[0] = 9'h000;
    rom[5] = 9'b111_000_011;
    rom[7] = 9'b110_000_011;
    rom[9] = HALT_WORD;

    prog_ctr = '0; cond_flag = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    model_reset();

    @(negedge clk);
    apply_reset();

    // Plain fetch of a non-branch, seeding lut[3] late in the period.
    run_period(12'd0, 1'b0, CYCLES, 6, 5'd3, 12'h040, 1'b0);
    // JMP through lut[3].
    run_period(12'd5, 1'b0, CYCLES, -1, '0, '0, 1'b0);
    // BR not taken, then taken with a fresh lut[3].
    run_period(12'd7, 1'b0, CYCLES, 8, 5'd3, 12'h123, 1'b0);
    run_period(12'd7, 1'b1, CYCLES, -1, '0, '0, 1'b0);
    // LUT write colliding with each instance's decode cycle.
    run_period(12'd5, 1'b0, CYCLES, dec_ph(1), 5'd3, 12'h3AB, 1'b0);
    run_period(12'd5, 1'b0, CYCLES, dec_ph(0), 5'd3, 12'h055, 1'b0);
    run_period(12'd5, 1'b0, CYCLES, -1, '0, '0, 1'b0);

    random_periods(20);

    // Reset while holding a branch request.
    run_period(12'd5, 1'b0, 6, -1, '0, '0, 1'b0);
    apply_reset();
    run_period(12'd5, 1'b1, CYCLES, -1, '0, '0, 1'b0);

    random_periods(10);

    // Halt, then stay quiet for 30 more cycles.
    run_period(12'd9, 1'b0, CYCLES + 30, -1, '0, '0, 1'b1);
    apply_reset();
    run_period(12'd0, 1'b0, CYCLES, -1, '0, '0, 1'b0);
    random_periods(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
